// File: rtl/wbram_stream_writer_if.sv
// Signal bundle around wbram_stream_writer: layer config, weight stream, BRAM port A and buffer pointers.
// The writer takes the master view; the producer, BRAMs and reader together take the slave view.
interface wbram_stream_writer_if #(
    parameter int STREAM_WIDTH = 128,
    parameter int NUM_BANKS    = 16,
    parameter int WBRAM_DEPTH  = 256
);
    localparam int AW = $clog2(WBRAM_DEPTH);
    localparam int CW = $clog2(WBRAM_DEPTH/2) + 1;

    logic [CW-1:0]                     cfg_words;
    logic                              cfg_valid;
    logic                              cfg_ready;
    logic [STREAM_WIDTH-1:0]           s_data;
    logic                              s_valid;
    logic                              s_last;
    logic                              s_ready;
    logic [NUM_BANKS*AW-1:0]           addrA;
    logic [NUM_BANKS*STREAM_WIDTH-1:0] doA;
    logic [NUM_BANKS-1:0]              enaA;
    logic [NUM_BANKS-1:0]              weA;
    logic [1:0]                        wr_pointer_data_r;
    logic                              wr_pointer_valid_r;
    logic                              wr_pointer_ready_r;
    logic [1:0]                        rd_pointer_data_l;
    logic                              rd_pointer_valid_l;
    logic                              rd_pointer_ready_l;
    logic                              err;

    modport master (
        input  cfg_words, cfg_valid, s_data, s_valid, s_last,
               wr_pointer_ready_r, rd_pointer_data_l, rd_pointer_valid_l,
        output cfg_ready, s_ready, addrA, doA, enaA, weA,
               wr_pointer_data_r, wr_pointer_valid_r, rd_pointer_ready_l, err
    );

    modport slave (
        output cfg_words, cfg_valid, s_data, s_valid, s_last,
               wr_pointer_ready_r, rd_pointer_data_l, rd_pointer_valid_l,
        input  cfg_ready, s_ready, addrA, doA, enaA, weA,
               wr_pointer_data_r, wr_pointer_valid_r, rd_pointer_ready_l, err
    );
endinterface

// File: rtl/wbram_stream_writer.sv
// Streams one layer of weights round-robin into the banked BRAMs, double-buffered, and hands each
// filled half to the reader through the pointer handshake. Write strobe lags the accepted beat by one cycle.
module wbram_stream_writer #(
    parameter int STREAM_WIDTH = 128,
    parameter int NUM_BANKS    = 16,
    parameter int WBRAM_DEPTH  = 256
) (
    input  logic                 clk,
    input  logic                 rst_n,
    wbram_stream_writer_if.master bus
);
    localparam int AW   = $clog2(WBRAM_DEPTH);
    localparam int CW   = $clog2(WBRAM_DEPTH/2) + 1;
    localparam int BW   = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
    localparam logic [CW-1:0] HALF_W    = CW'(WBRAM_DEPTH/2);
    localparam logic [BW-1:0] LAST_BANK = BW'(NUM_BANKS-1);

    typedef enum logic [1:0] {IDLE, FILL, DRAIN, HANDOFF} state_t;

    state_t                  state_q, state_d;
    logic [1:0]              free_q, free_d;
    logic                    cur_buf_q, cur_buf_d;
    logic [BW-1:0]           bank_cnt_q, bank_cnt_d;
    logic [CW-1:0]           word_cnt_q, word_cnt_d;
    logic [CW-1:0]           words_q, words_d;
    logic                    err_q, err_d;
    logic                    live_q;
    logic [NUM_BANKS-1:0]    wen_q, wen_d;
    logic [AW-1:0]           waddr_q, waddr_d;
    logic [STREAM_WIDTH-1:0] wdata_q, wdata_d;
    logic                    cfg_rdy, s_rdy, final_beat;
    logic                    unused_rd_hi;

    assign unused_rd_hi = bus.rd_pointer_data_l[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            free_q     <= 2'b11;
            cur_buf_q  <= 1'b0;
            bank_cnt_q <= '0;
            word_cnt_q <= '0;
            words_q    <= '0;
            err_q      <= 1'b0;
            live_q     <= 1'b0;
            wen_q      <= '0;
            waddr_q    <= '0;
            wdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            free_q     <= free_d;
            cur_buf_q  <= cur_buf_d;
            bank_cnt_q <= bank_cnt_d;
            word_cnt_q <= word_cnt_d;
            words_q    <= words_d;
            err_q      <= err_d;
            live_q     <= 1'b1;
            wen_q      <= wen_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        free_d     = free_q;
        cur_buf_d  = cur_buf_q;
        bank_cnt_d = bank_cnt_q;
        word_cnt_d = word_cnt_q;
        words_d    = words_q;
        err_d      = err_q;
        wen_d      = '0;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        cfg_rdy    = 1'b0;
        s_rdy      = 1'b0;
        final_beat = 1'b0;

        case (state_q)
            IDLE: begin
                cfg_rdy = live_q & free_q[cur_buf_q];
                if (bus.cfg_valid && cfg_rdy) begin
                    bank_cnt_d = '0;
                    word_cnt_d = '0;
                    if (bus.cfg_words > HALF_W) begin
                        words_d = HALF_W;
                        err_d   = 1'b1;
                    end else begin
                        words_d = bus.cfg_words;
                    end
                    state_d = (bus.cfg_words == '0) ? DRAIN : FILL;
                end
            end
            FILL: begin
                s_rdy      = 1'b1;
                final_beat = (word_cnt_q == words_q - CW'(1)) && (bank_cnt_q == LAST_BANK);
                if (bus.s_valid) begin
                    wen_d[bank_cnt_q] = 1'b1;
                    waddr_d = {cur_buf_q, word_cnt_q[AW-2:0]};
                    wdata_d = bus.s_data;
                    // Beat count ends the layer; s_last only cross-checks it.
                    if (bus.s_last != final_beat)
                        err_d = 1'b1;
                    if (bank_cnt_q == LAST_BANK) begin
                        bank_cnt_d = '0;
                        word_cnt_d = word_cnt_q + CW'(1);
                    end else begin
                        bank_cnt_d = bank_cnt_q + BW'(1);
                    end
                    if (final_beat)
                        state_d = DRAIN;
                end
            end
            DRAIN: state_d = HANDOFF;
            HANDOFF: begin
                if (bus.wr_pointer_ready_r) begin
                    free_d[cur_buf_q] = 1'b0;
                    cur_buf_d         = ~cur_buf_q;
                    state_d           = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Release is applied after the claim so a same-buffer collision leaves it free.
        if (bus.rd_pointer_valid_l && live_q) begin
            if (free_q[bus.rd_pointer_data_l[0]])
                err_d = 1'b1;
            free_d[bus.rd_pointer_data_l[0]] = 1'b1;
        end
    end

    assign bus.cfg_ready          = cfg_rdy;
    assign bus.s_ready            = s_rdy;
    assign bus.addrA              = {NUM_BANKS{waddr_q}};
    assign bus.doA                = {NUM_BANKS{wdata_q}};
    assign bus.enaA               = wen_q;
    assign bus.weA                = wen_q;
    assign bus.wr_pointer_valid_r = (state_q == HANDOFF);
    assign bus.wr_pointer_data_r  = {1'b0, (state_q == HANDOFF) & cur_buf_q};
    assign bus.rd_pointer_ready_l = live_q;
    assign bus.err                = err_q;
endmodule
